// File: rtl/bcd_down_counter_7seg.sv
// Single-digit BCD down counter with prescaled step tick, borrow output and
// registered active-low 7-segment drive. Define HOLD_AT_ZERO_EN for one-shot countdown (stops at 0).
module bcd_down_counter_7seg #(
  parameter int unsigned TICK_DIV = 6000000,
  parameter int unsigned PRESC_W  = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);
  localparam logic [6:0]         SEG_NINE = 7'b0000100;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         digit_q, digit_d;
  logic               borrow_q, borrow_d;
  logic [6:0]         seg_q, seg_d;
  logic               tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      digit_q  <= 4'd9;
      borrow_q <= 1'b0;
      seg_q    <= SEG_NINE;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      borrow_q <= borrow_d;
      seg_q    <= seg_d;
    end
  end

  // Priority below reset: load, then tick, then hold.
  always_comb begin
    presc_d  = presc_q;
    digit_d  = digit_q;
    borrow_d = 1'b0;
    tick     = en && (presc_q == PRESC_TC);
    if (load) begin
      digit_d = (load_val > 4'd9) ? 4'd9 : load_val;
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (digit_q > 4'd9) begin
          digit_d = 4'd9;
        end else if (digit_q == 4'd0) begin
`ifdef HOLD_AT_ZERO_EN
          digit_d = 4'd0;
`else
          digit_d  = 4'd9;
          borrow_d = 1'b1;
`endif
        end else begin
          digit_d = digit_q - 4'd1;
`ifdef HOLD_AT_ZERO_EN
          borrow_d = (digit_q == 4'd1);
`endif
        end
      end
    end
  end

  // Segment order {a,b,c,d,e,f,g}, 0 = lit; invalid codes blank the display.
  always_comb begin
    seg_d = 7'b1111111;
    case (digit_q)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = SEG_NINE;
      default: seg_d = 7'b1111111;
    endcase
  end

  assign digit  = digit_q;
  assign borrow = borrow_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_bcd_down_counter_7seg.sv
// Bench for bcd_down_counter_7seg: vector table plus reference model feeding an
// expected-value queue that is drained after every clock edge.
module tb_bcd_down_counter_7seg;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       borrow;
  logic       sa, sb, sc, sd, se, sf, sg;
  logic [6:0] seg;
  assign seg = {sa, sb, sc, sd, se, sf, sg};

  bcd_down_counter_7seg #(.TICK_DIV(TD), .PRESC_W(27)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .digit(digit), .borrow(borrow),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       b;
    logic [6:0] s;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic       r, e, l;
    logic [3:0] v;
    int         xd;
  } vec_t;
  vec_t vt[22];

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  int         nerr = 0;
  int         nchk = 0;
  int         m_presc = 0;
  logic [3:0] m_d = 4'd9;
  logic       m_b = 1'b0;
  logic [6:0] m_s = 7'b0000100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, queue its prediction, check after the edge.
  task automatic cycle(input logic r, input logic e, input logic l, input logic [3:0] v);
    exp_t x;
    bit   tk;
    rst = r; en = e; load = l; load_val = v;
    if (r) begin
      m_presc = 0; m_d = 4'd9; m_b = 1'b0; m_s = seg_tab[9];
    end else begin
      m_s = seg_tab[m_d];
      m_b = 1'b0;
      if (l) begin
        m_d = (v > 4'd9) ? 4'd9 : v;
        m_presc = 0;
      end else if (e) begin
        tk = (m_presc == TD - 1);
        m_presc = tk ? 0 : m_presc + 1;
        if (tk) begin
          if (m_d == 4'd0) begin
`ifdef HOLD_AT_ZERO_EN
            m_d = 4'd0;
`else
            m_d = 4'd9; m_b = 1'b1;
`endif
          end else begin
`ifdef HOLD_AT_ZERO_EN
            m_b = (m_d == 4'd1);
`endif
            m_d = m_d - 4'd1;
          end
        end
      end
    end
    q.push_back('{d: m_d, b: m_b, s: m_s});
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("digit", digit, x.d);
    chk("borrow", borrow, x.b);
    chk("segments", seg, x.s);
  endtask

  initial begin
    int nb;
    int n;
    // {rst, en, load, load_val, expected digit after the edge}
    vt[0]  = '{1, 1, 0, 0, 9};   vt[1]  = '{1, 1, 0, 0, 9};
    vt[2]  = '{0, 1, 0, 0, 9};   vt[3]  = '{0, 1, 0, 0, 9};
    vt[4]  = '{0, 1, 0, 0, 9};   vt[5]  = '{0, 1, 0, 0, 8};
    vt[6]  = '{0, 1, 0, 0, 8};   vt[7]  = '{0, 1, 1, 3, 3};
    vt[8]  = '{0, 1, 0, 0, 3};   vt[9]  = '{0, 1, 0, 0, 3};
    vt[10] = '{0, 1, 0, 0, 3};   vt[11] = '{0, 1, 0, 0, 2};
    vt[12] = '{0, 1, 1, 12, 9};  vt[13] = '{0, 1, 0, 0, 9};
    vt[14] = '{0, 1, 0, 0, 9};   vt[15] = '{0, 1, 0, 0, 9};
    vt[16] = '{0, 1, 1, 7, 7};   vt[17] = '{1, 1, 1, 2, 9};
    vt[18] = '{0, 1, 0, 0, 9};   vt[19] = '{0, 1, 0, 0, 9};
    vt[20] = '{0, 1, 0, 0, 9};   vt[21] = '{0, 1, 0, 0, 8};

    for (int i = 0; i < 22; i++) begin
      cycle(vt[i].r, vt[i].e, vt[i].l, vt[i].v);
      chk($sformatf("vec%0d_digit", i), digit, vt[i].xd);
    end

    // Full countdown from reset: one borrow pulse in 40 cycles.
    cycle(1, 1, 0, 0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, 0);
      if (borrow) begin
        nb++;
`ifndef HOLD_AT_ZERO_EN
        chk("borrow_with_nine", digit, 9);
`endif
      end
    end
    chk("borrow_count_run", nb, 1);

    // Freeze at 5 with prescaler at 2: resume needs only the remaining 2 cycles.
    cycle(0, 1, 1, 5);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    chk("frozen_digit", digit, 5);
    n = 0;
    while (digit == 4'd5 && n < 8) begin
      cycle(0, 1, 0, 0);
      n++;
    end
    chk("resume_latency", n, 2);
    chk("resume_digit", digit, 4);

`ifdef HOLD_AT_ZERO_EN
    cycle(0, 1, 1, 2);
    nb = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(0, 1, 0, 0);
      if (borrow) nb++;
    end
    chk("hold_digit", digit, 0);
    chk("hold_borrow_count", nb, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bcd_down_counter_7seg.md
Name: bcd_down_counter_7seg

Overview:
- Decrementing single-digit BCD counter with a 7-segment display encoder; the count-down counterpart to the board's incrementing digit counter.
- A prescaler on the board system clock produces a step tick; each tick decrements the digit 9→0 and wraps.
- The digit drives active-low segment outputs a..g directly to the Vaman 7-segment header.
- A borrow pulse allows cascading into a higher digit.

Parameters:
TICK_DIV, 6000000, clock cycles per count step (prescaler period); legal range 2..2^PRESC_W.
PRESC_W, 27, prescaler counter width in bits.

Ports:
clk  input  1  system clock (Sys_Clk0 from the qlal4s3b cell macro)
rst  input  1  synchronous, active-high reset
en  input  1  count enable; 0 freezes prescaler and digit
load  input  1  synchronous load strobe
load_val  input  4  BCD value loaded on load
digit  output  4  current BCD digit, 0..9
borrow  output  1  one-cycle pulse on wrap (see Behaviour)
a, b, c, d, e, f, g  output  1 each  segment drives, active-low (0 = lit)

Behaviour:
- All state updates on posedge clk; rst is synchronous and active-high, and has the highest priority.
- Reset values:
  - prescaler = 0, digit = 9, borrow = 0.
  - {a,b,c,d,e,f,g} = 0000100 (pattern for 9).
- Prescaler:
  - When en=1 and load=0, the prescaler counts 0..TICK_DIV-1 and then returns to 0.
  - tick is an internal signal, asserted for the cycle in which prescaler == TICK_DIV-1 and en=1.
  - The step period is exactly TICK_DIV cycles.
- Priority per cycle: rst > load > tick > hold.
- Load:
  - digit ← load_val; values 10..15 clamp to 9.
  - prescaler ← 0; borrow = 0.
  - load is honoured regardless of en.
- Tick:
  - digit ≠ 0: digit ← digit-1, borrow = 0.
  - digit = 0: digit ← 9, borrow = 1 for exactly that cycle.
- en=0 with no load: prescaler and digit hold; borrow = 0.
- borrow is registered and asserts in the same cycle in which the new digit (9) appears.
- Segment outputs:
  - Registered, decoded from the digit register; they reflect a new digit 1 cycle after digit changes.
  - The digit → segment latency is always 1 cycle.
- Segment table {a,b,c,d,e,f,g}, active-low:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- digit never holds 10..15. If it ever does, the segment decoder drives 1111111 (blank) and the next tick loads 9.
- Reset mid-count: the prescaler phase is discarded; the first tick after reset release occurs TICK_DIV cycles later, provided en=1.

Optional Feature:
Macro: HOLD_AT_ZERO_EN
- Without the macro: wrap-around 0→9 with a borrow pulse, as specified above.
- With the macro defined: one-shot countdown mode.
  - A tick at digit 0 leaves digit at 0.
  - borrow pulses for one cycle on the tick that moves digit 1→0, and never on a tick at 0.
  - The prescaler keeps running while en=1.
  - Only load or rst restarts the count.
- Port list is identical in both builds.

Test Plan:
- TICK_DIV=4, rst held 2 cycles then released, en=1 → digit=9 and segments 0000100 during reset; digit=8 on cycle 4 after release; segments 0000000 on cycle 5.
- TICK_DIV=4, en=1, run 40 cycles from reset → digit sequence 9,8,...,0,9; borrow=1 for exactly one cycle, coincident with digit=9 after 0; every segment pattern matches the table.
- load=1 with load_val=3 mid-prescaler, then load_val=12 → digit=3 and prescaler restarts (next tick exactly 4 cycles later); second load gives digit=9.
- en=0 for 10 cycles mid-count at digit=5 → digit, segments and prescaler frozen; after en=1, decrement occurs after the remaining prescaler cycles only.
- load and tick in the same cycle (load_val=7) → digit=7, no decrement, borrow=0; rst asserted in the same cycle as load → digit=9.
- HOLD_AT_ZERO_EN build, load_val=2, TICK_DIV=4 → 2,1,0 then digit stays 0 for ≥3 further ticks; borrow pulses once on 1→0 only.
